// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the rggen host interfaces: the APB-side FSM state
// encoding, the index of the error flag in the register-block status, and
// the per-lane strobe-to-mask expansion.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMAND  = 2'd1,
    RESPONSE = 2'd2
  } rggen_host_if_state_e;

  // Bit of the register-block status word that flags an access error.
  localparam int RGGEN_STATUS_ERROR_BIT = 0;

  // Expands one byte strobe into its 8-bit byte-lane mask.
  function automatic logic [7:0] rggen_strb_to_mask(input logic strb);
    return {8{strb}};
  endfunction

endpackage

// File: rtl/rggen_host_if_timer.sv
// Response timeout counter for the host interface. It is held at zero while
// clear is high, counts while enable is high, and flags expired on the cycle
// the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 removes the counter
// and ties expired low.
module rggen_host_if_timer #(
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_timer_inputs;
      assign unused_timer_inputs = ^{clk, rst_n, clear, enable};
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

      logic [COUNT_WIDTH-1:0] count_reg;

      // Count waiting cycles; holding at the last value avoids wrap-around.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable && !expired) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign expired = enable && (count_reg == COUNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/rggen_host_if_apb_timed.sv
// APB completer front-end for an rggen register block, with an optional
// response timeout. A setup phase latches the request, COMMAND presents it to
// the register block until it responds (or the timer expires), and RESPONSE
// drives pready for one cycle.
// Build option: RGGEN_APB_PROT_CHECK_EN rejects non-secure (pprot[1]=1)
// accesses with pslverr without issuing a command.
module rggen_host_if_apb_timed
  import rggen_rtl_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES      = 0
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
  output logic                           o_pready,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pslverr,
  output logic                           o_command_valid,
  output logic                           o_write,
  output logic                           o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_response_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [1:0]                     i_status
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  rggen_host_if_state_e           state_reg, state_next;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_reg, address_next;
  logic                           write_reg, write_next;
  logic [DATA_WIDTH-1:0]          write_data_reg, write_data_next;
  logic [STRB_WIDTH-1:0]          strb_reg, strb_next;
  logic [DATA_WIDTH-1:0]          read_data_reg, read_data_next;
  logic                           error_reg, error_next;
  logic                           timer_expired;
  logic                           setup_phase;

  // Only the low address bits reach the register block; the error flag is
  // the only status bit consumed; pprot matters only with the check enabled.
  logic unused_inputs;
  assign unused_inputs = ^{i_paddr, i_pprot, i_status};

  assign setup_phase = i_psel && !i_penable;

  rggen_host_if_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg != COMMAND),
    .enable  (state_reg == COMMAND),
    .expired (timer_expired)
  );

  // State and request/response registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      address_reg    <= '0;
      write_reg      <= 1'b0;
      write_data_reg <= '0;
      strb_reg       <= '0;
      read_data_reg  <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      address_reg    <= address_next;
      write_reg      <= write_next;
      write_data_reg <= write_data_next;
      strb_reg       <= strb_next;
      read_data_reg  <= read_data_next;
      error_reg      <= error_next;
    end
  end

  // Next-state logic: latch on setup, wait for response or timeout, answer.
  always_comb begin
    state_next      = state_reg;
    address_next    = address_reg;
    write_next      = write_reg;
    write_data_next = write_data_reg;
    strb_next       = strb_reg;
    read_data_next  = read_data_reg;
    error_next      = error_reg;
    case (state_reg)
      IDLE: begin
        // An access phase seen without a setup phase is ignored here.
        if (setup_phase) begin
          address_next    = i_paddr[LOCAL_ADDRESS_WIDTH-1:0];
          write_next      = i_pwrite;
          write_data_next = i_pwdata;
          strb_next       = i_pstrb;
`ifdef RGGEN_APB_PROT_CHECK_EN
          if (i_pprot[1]) begin
            state_next     = RESPONSE;
            read_data_next = '0;
            error_next     = 1'b1;
          end else begin
            state_next = COMMAND;
          end
`else
          state_next = COMMAND;
`endif
        end
      end
      COMMAND: begin
        // A dropped psel aborts the transfer; a real response beats a
        // timeout landing in the same cycle.
        if (!i_psel) begin
          state_next = IDLE;
        end else if (i_response_ready) begin
          state_next     = RESPONSE;
          read_data_next = write_reg ? '0 : i_read_data;
          error_next     = i_status[RGGEN_STATUS_ERROR_BIT];
        end else if (timer_expired) begin
          state_next     = RESPONSE;
          read_data_next = '0;
          error_next     = 1'b1;
        end
      end
      RESPONSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_command_valid = (state_reg == COMMAND);
  assign o_write         = o_command_valid && write_reg;
  assign o_read          = o_command_valid && !write_reg;
  assign o_address       = address_reg;
  assign o_write_data    = write_data_reg;

  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_mask
      assign o_write_mask[gi*8+:8] = rggen_strb_to_mask(strb_reg[gi]);
    end
  endgenerate

  assign o_pready  = (state_reg == RESPONSE);
  assign o_pslverr = o_pready && error_reg;
  assign o_prdata  = o_pready ? read_data_reg : '0;

endmodule

// File: tb/tb_rggen_host_if_apb_timed.sv
// Directed testbench for rggen_host_if_apb_timed with TIMEOUT_CYCLES=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// that same point, away from the edge.
module tb_rggen_host_if_apb_timed;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_paddr;
  logic [2:0]  i_pprot;
  logic        i_psel;
  logic        i_penable;
  logic        i_pwrite;
  logic [31:0] i_pwdata;
  logic [3:0]  i_pstrb;
  logic        o_pready;
  logic [31:0] o_prdata;
  logic        o_pslverr;
  logic        o_command_valid;
  logic        o_write;
  logic        o_read;
  logic [15:0] o_address;
  logic [31:0] o_write_data;
  logic [31:0] o_write_mask;
  logic        i_response_ready;
  logic [31:0] i_read_data;
  logic [1:0]  i_status;

  int tests_run;
  int tests_failed;

  rggen_host_if_apb_timed #(
    .DATA_WIDTH          (32),
    .HOST_ADDRESS_WIDTH  (16),
    .LOCAL_ADDRESS_WIDTH (16),
    .TIMEOUT_CYCLES      (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_paddr          (i_paddr),
    .i_pprot          (i_pprot),
    .i_psel           (i_psel),
    .i_penable        (i_penable),
    .i_pwrite         (i_pwrite),
    .i_pwdata         (i_pwdata),
    .i_pstrb          (i_pstrb),
    .o_pready         (o_pready),
    .o_prdata         (o_prdata),
    .o_pslverr        (o_pslverr),
    .o_command_valid  (o_command_valid),
    .o_write          (o_write),
    .o_read           (o_read),
    .o_address        (o_address),
    .o_write_data     (o_write_data),
    .o_write_mask     (o_write_mask),
    .i_response_ready (i_response_ready),
    .i_read_data      (i_read_data),
    .i_status         (i_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_setup(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] prot);
    i_paddr   = addr;
    i_pwrite  = wr;
    i_pwdata  = wd;
    i_pstrb   = st;
    i_pprot   = prot;
    i_psel    = 1'b1;
    i_penable = 1'b0;
  endtask

  task automatic apb_release();
    i_psel    = 1'b0;
    i_penable = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({o_pready, o_pslverr, o_command_valid, o_write, o_read} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, expected 00000", {o_pready, o_pslverr, o_command_valid, o_write, o_read});
    end
    tests_run++;
    if ({o_prdata, o_address, o_write_data, o_write_mask} !== 112'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h, expected 0", {o_prdata, o_address, o_write_data, o_write_mask});
    end
  endtask

  task automatic test_write();
    apb_setup(16'h0010, 1'b1, 32'hA5A5_0000, 4'b1100, 3'b000);
    tests_run++;
    if (o_command_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_setup_valid: got %b, expected 0", o_command_valid);
    end
    tick();  // cycle 1: COMMAND
    i_penable = 1'b1;
    tests_run++;
    if ({o_command_valid, o_write, o_read, o_pready} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL write_cmd_flags: got %b, expected 1100", {o_command_valid, o_write, o_read, o_pready});
    end
    tests_run++;
    if ({o_address, o_write_data, o_write_mask} !== {16'h0010, 32'hA5A5_0000, 32'hFFFF_0000}) begin
      tests_failed++;
      $display("FAIL write_cmd_fields: got %h %h %h, expected 0010 a5a50000 ffff0000", o_address, o_write_data, o_write_mask);
    end
    i_response_ready = 1'b1;
    i_read_data      = 32'hDEAD_BEEF;
    i_status         = 2'b00;
    tick();  // cycle 2: RESPONSE
    i_response_ready = 1'b0;
    tests_run++;
    if ({o_pready, o_pslverr, o_command_valid, o_prdata} !== {3'b100, 32'h0}) begin
      tests_failed++;
      $display("FAIL write_response: got %b%b%b %h, expected 100 00000000", o_pready, o_pslverr, o_command_valid, o_prdata);
    end
    tick();  // cycle 3: IDLE
    tests_run++;
    if (o_pready !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_pready_single: got %b, expected 0", o_pready);
    end
    apb_release();
  endtask

  task automatic test_read();
    apb_setup(16'h0024, 1'b0, 32'h0, 4'b0000, 3'b000);
    i_read_data = 32'h1234_5678;
    tick();
    i_penable = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tests_run++;
      if ({o_command_valid, o_read, o_write, o_pready, o_prdata} !== {4'b1100, 32'h0}) begin
        tests_failed++;
        $display("FAIL read_wait_c%0d: got %b%b%b%b %h, expected 1100 00000000", c, o_command_valid, o_read, o_write, o_pready, o_prdata);
      end
      if (c == 3) begin
        i_response_ready = 1'b1;
        i_status         = 2'b10;  // upper status bit is not an error
      end
      tick();
    end
    i_response_ready = 1'b0;
    i_status         = 2'b00;
    tests_run++;
    if ({o_pready, o_pslverr, o_prdata} !== {2'b10, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL read_response: got %b%b %h, expected 10 12345678", o_pready, o_pslverr, o_prdata);
    end
    tick();
    tests_run++;
    if ({o_pready, o_prdata} !== 33'h0) begin
      tests_failed++;
      $display("FAIL read_after: got %b %h, expected 0 00000000", o_pready, o_prdata);
    end
    apb_release();
  endtask

  task automatic test_timeout();
    int n;
    apb_setup(16'h0030, 1'b0, 32'h0, 4'b0000, 3'b000);
    i_read_data = 32'hFFFF_FFFF;
    tick();
    i_penable = 1'b1;
    n = 0;
    while (o_command_valid === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL timeout_cmd_cycles: got %0d, expected 4", n);
    end
    tests_run++;
    if ({o_pready, o_pslverr, o_prdata} !== {2'b11, 32'h0}) begin
      tests_failed++;
      $display("FAIL timeout_response: got %b%b %h, expected 11 00000000", o_pready, o_pslverr, o_prdata);
    end
    tick();
    tests_run++;
    if (o_pready !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pready_single: got %b, expected 0", o_pready);
    end
    apb_release();
  endtask

  task automatic test_timeout_race();
    apb_setup(16'h0034, 1'b0, 32'h0, 4'b0000, 3'b000);
    i_read_data = 32'hCAFE_F00D;
    tick();
    i_penable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (o_command_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL race_cmd_c%0d: got %b, expected 1", c, o_command_valid);
      end
      if (c == 4) begin
        i_response_ready = 1'b1;
        i_status         = 2'b01;
      end
      tick();
    end
    i_response_ready = 1'b0;
    i_status         = 2'b00;
    tests_run++;
    if ({o_pready, o_pslverr, o_prdata} !== {2'b11, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL race_response: got %b%b %h, expected 11 cafef00d", o_pready, o_pslverr, o_prdata);
    end
    tick();
    apb_release();
  endtask

  task automatic test_violation();
    apb_setup(16'h0040, 1'b0, 32'h0, 4'b0000, 3'b000);
    tick();
    i_penable = 1'b1;
    tests_run++;
    if (o_command_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL viol_cmd: got %b, expected 1", o_command_valid);
    end
    apb_release();
    i_response_ready = 1'b1;
    i_read_data      = 32'h0000_0055;
    tick();
    i_response_ready = 1'b0;
    tests_run++;
    if ({o_command_valid, o_pready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL viol_abort: got %b, expected 00", {o_command_valid, o_pready});
    end
    tick();
    tests_run++;
    if ({o_pready, o_prdata} !== 33'h0) begin
      tests_failed++;
      $display("FAIL viol_discard: got %b %h, expected 0 00000000", o_pready, o_prdata);
    end
    // Access phase with no setup phase in IDLE.
    i_psel    = 1'b1;
    i_penable = 1'b1;
    tick();
    tests_run++;
    if (o_command_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL penable_no_setup: got %b, expected 0", o_command_valid);
    end
    tick();
    tests_run++;
    if ({o_command_valid, o_pready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL penable_no_setup_hold: got %b, expected 00", {o_command_valid, o_pready});
    end
    apb_release();
    tick();
  endtask

  task automatic test_reset_mid();
    apb_setup(16'h0050, 1'b1, 32'h1111_2222, 4'b1111, 3'b000);
    tick();
    i_penable = 1'b1;
    tests_run++;
    if ({o_command_valid, o_write_data} !== {1'b1, 32'h1111_2222}) begin
      tests_failed++;
      $display("FAIL rstmid_cmd: got %b %h, expected 1 11112222", o_command_valid, o_write_data);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_command_valid, o_write, o_read, o_pready, o_address, o_write_data, o_write_mask} !== 84'h0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got %b%b%b%b %h %h %h, expected all 0", o_command_valid, o_write, o_read, o_pready, o_address, o_write_data, o_write_mask);
    end
    tick();
    rst_n = 1'b1;
    apb_setup(16'h0060, 1'b0, 32'h0, 4'b0000, 3'b000);
    tick();
    i_penable = 1'b1;
    tests_run++;
    if ({o_command_valid, o_read, o_address} !== {2'b11, 16'h0060}) begin
      tests_failed++;
      $display("FAIL rstmid_next_cmd: got %b%b %h, expected 11 0060", o_command_valid, o_read, o_address);
    end
    i_response_ready = 1'b1;
    i_read_data      = 32'h0BAD_CAFE;
    tick();
    i_response_ready = 1'b0;
    tests_run++;
    if ({o_pready, o_pslverr, o_prdata} !== {2'b10, 32'h0BAD_CAFE}) begin
      tests_failed++;
      $display("FAIL rstmid_next_resp: got %b%b %h, expected 10 0badcafe", o_pready, o_pslverr, o_prdata);
    end
    tick();
    apb_release();
  endtask

  task automatic test_back_to_back();
    apb_setup(16'h0070, 1'b1, 32'h0000_BEEF, 4'b0011, 3'b000);
    tick();  // cycle 1
    i_penable        = 1'b1;
    i_response_ready = 1'b1;
    tests_run++;
    if (o_write_mask !== 32'h0000_FFFF) begin
      tests_failed++;
      $display("FAIL b2b_mask: got %h, expected 0000ffff", o_write_mask);
    end
    tick();  // cycle 2
    i_response_ready = 1'b0;
    tests_run++;
    if (o_pready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first_pready: got %b, expected 1", o_pready);
    end
    tick();  // cycle 3: IDLE, next setup
    apb_setup(16'h0074, 1'b0, 32'h0, 4'b0000, 3'b000);
    tests_run++;
    if ({o_pready, o_command_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %b, expected 00", {o_pready, o_command_valid});
    end
    tick();  // cycle 4
    i_penable        = 1'b1;
    i_response_ready = 1'b1;
    i_read_data      = 32'hA1B2_C3D4;
    tests_run++;
    if ({o_command_valid, o_read, o_address} !== {2'b11, 16'h0074}) begin
      tests_failed++;
      $display("FAIL b2b_second_cmd: got %b%b %h, expected 11 0074", o_command_valid, o_read, o_address);
    end
    tick();  // cycle 5
    i_response_ready = 1'b0;
    tests_run++;
    if ({o_pready, o_prdata} !== {1'b1, 32'hA1B2_C3D4}) begin
      tests_failed++;
      $display("FAIL b2b_second_resp: got %b %h, expected 1 a1b2c3d4", o_pready, o_prdata);
    end
    tick();
    apb_release();
  endtask

  task automatic test_prot();
    apb_setup(16'h0080, 1'b0, 32'h0, 4'b0000, 3'b010);
    i_read_data = 32'h7777_7777;
`ifdef RGGEN_APB_PROT_CHECK_EN
    tick();  // cycle 1: straight to RESPONSE
    i_penable = 1'b1;
    tests_run++;
    if ({o_command_valid, o_pready, o_pslverr, o_prdata} !== {3'b011, 32'h0}) begin
      tests_failed++;
      $display("FAIL prot_reject: got %b%b%b %h, expected 011 00000000", o_command_valid, o_pready, o_pslverr, o_prdata);
    end
    tick();
    tests_run++;
    if ({o_command_valid, o_pready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL prot_after: got %b, expected 00", {o_command_valid, o_pready});
    end
`else
    tick();
    i_penable = 1'b1;
    tests_run++;
    if (o_command_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL prot_ignored_cmd: got %b, expected 1", o_command_valid);
    end
    i_response_ready = 1'b1;
    tick();
    i_response_ready = 1'b0;
    tests_run++;
    if ({o_pready, o_pslverr, o_prdata} !== {2'b10, 32'h7777_7777}) begin
      tests_failed++;
      $display("FAIL prot_ignored_resp: got %b%b %h, expected 10 77777777", o_pready, o_pslverr, o_prdata);
    end
    tick();
`endif
    i_pprot = 3'b000;
    apb_release();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    rst_n            = 1'b1;
    i_paddr          = '0;
    i_pprot          = '0;
    i_psel           = 1'b0;
    i_penable        = 1'b0;
    i_pwrite         = 1'b0;
    i_pwdata         = '0;
    i_pstrb          = '0;
    i_response_ready = 1'b0;
    i_read_data      = '0;
    i_status         = '0;
    #3 rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_write();
    test_read();
    test_timeout();
    test_timeout_race();
    test_violation();
    test_reset_mid();
    test_back_to_back();
    test_prot();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
